pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined integer adder/subtractor for the KGP-RISC datapath. It is the successor to the fixed 32-bit two-slice ripple adder and is built the same way, from equal-width segments, except that each segment is registered. That raises the clock ceiling for wide operands. The block takes one operation per cycle through a valid/ready handshake, supports add, add-with-carry, subtract and subtract-with-borrow, and produces carry, overflow and zero flags. The ALU and the address-generation path both use it.

## Interface
- `WIDTH`, 32: operand and result width in bits. Must be a multiple of `SEG`.
- `SEG`, 16: segment width. `STAGES = WIDTH/SEG` is the pipeline depth; `STAGES = 1` is legal.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept this cycle.
- `op`  in  2  operation code from the package: ADD, ADC, SUB, SBB.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `cin`  in  1  carry-in; used only by ADC and SBB.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB. For SUB/SBB, 1 means no borrow.
- `ovf`  out  1  signed overflow.
- `zero`  out  1  `sum == 0`.

## Operation
- **Effective operands:**
  - ADD: `b`, carry-in 0.
  - ADC: `b`, carry-in `cin`.
  - SUB: `~b`, carry-in 1.
  - SBB: `~b`, carry-in `cin` (`cin = 1` means no borrow pending).
- **Stage k** (0 to `STAGES-1`):
  - Adds segment k of `a` and the effective `b`, plus the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Registers the segment result and its carry-out.
  - Forwards the still-unused upper operand segments and the earlier result segments, so an operation's segments stay aligned as it moves down the pipe.
- **Final stage:**
  - Registers the `cout` of the top segment.
  - Computes `ovf = carry_into_MSB ^ carry_out_of_MSB`.
  - Computes `zero` as the NOR of all `sum` bits.
- **Pipeline enable:** `adv = !out_valid || out_ready`.
  - All stage registers, including the valid bits, load only when `adv` is 1.
  - `in_ready = adv`. This is combinational from `out_ready`; there is no combinational path from `in_valid`.
- **Valid bits:** each stage carries one. A bubble enters when `in_valid & in_ready` is 0. Bubbles are not collapsed, because the enable is global.
- **Operand width:** everything is exactly `WIDTH` bits. There is no sign extension and no saturation; wrap-around is modulo 2^WIDTH.

## Timing
- **Latency:** `STAGES` cycles from the accept edge to `out_valid` high, assuming no stalls. The default configuration has latency 2.
- **Throughput:** one operation per cycle while `out_ready` stays high.
- **Stall:** when `out_valid` is high and `out_ready` is low:
  - every stage holds;
  - `sum`, `cout`, `ovf` and `zero` stay stable;
  - `in_ready` is 0.
- **Simultaneous accept and drain:** legal in the same cycle; the pipe shifts by one.
- **`STAGES = 1`:** a single registered adder with latency 1 and the same handshake.
- **Reset:** while `rst_n` is low at a clock edge:
  - all valid bits clear;
  - `out_valid = 0`, `sum = 0`, `cout = 0`, `ovf = 0`, `zero = 0`;
  - `in_ready` is 1 in the first cycle after reset.
- **Reset mid-operation:** every operation in flight is discarded and never emitted.
- **Parameter check:** elaboration fails if `WIDTH % SEG != 0` or `SEG < 1`.

## Structure
- **Package `kgp_alu_pkg`:**
  - 2-bit op enum: ADD = 0, ADC = 1, SUB = 2, SBB = 3.
  - Localparam helper for `STAGES`.
  - Shared with the ALU decoder.
- **Sub-module `add_seg_stage`:**
  - One `SEG`-wide combinational segment adder plus its result and carry registers, with an enable and the synchronous active-low clear.
  - Instantiated `STAGES` times in a generate loop.
  - Operand skew and result alignment registers stay in the top module.

## Test plan
All cases use `WIDTH=32`, `SEG=16`, latency 2.
- **Cross-segment carry:** ADD `0x0000FFFF + 0x00000001` → two cycles later `sum = 0x00010000`, `cout = 0`, `ovf = 0`, `zero = 0`.
- **Signed overflow and full carry-out:**
  - ADD `0x7FFFFFFF + 0x00000001` → `sum = 0x80000000`, `ovf = 1`, `cout = 0`.
  - ADD `0xFFFFFFFF + 0x00000001` → `sum = 0`, `cout = 1`, `zero = 1`, `ovf = 0`.
- **Subtract:**
  - SUB `5 - 5` → `sum = 0`, `zero = 1`, `cout = 1`.
  - SUB `0 - 1` → `sum = 0xFFFFFFFF`, `cout = 0`, `ovf = 0`.
  - SBB `10 - 3` with `cin = 0` → `sum = 6`.
- **Back-to-back with stall:** 6 consecutive operations with `in_valid` held high; `out_ready` low for 3 cycles after the first result appears.
  - Results emerge in order with none lost or duplicated.
  - Outputs hold steady and `in_ready = 0` during the stall.
  - Throughput returns to 1 per cycle afterwards.
- **Reset mid-flight:** `rst_n` low for one cycle while 2 operations are in the pipe.
  - Next cycle: `out_valid = 0` and all outputs 0.
  - Neither operation ever appears.
  - A new ADD issued after reset returns correctly two cycles later.
- **Single-stage build:** `SEG = 32` → latency 1; the ADD, SUB and stall cases above repeated with the same results.

Source files
------------

// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions: the operation encoding used by the adder and the
// ALU decoder, plus the helpers that turn an opcode into effective operands.
package kgp_alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    ADC = 2'd1,
    SUB = 2'd2,
    SBB = 2'd3
  } alu_op_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SEG   = 16;

  // Pipeline depth for a given operand/segment split. A non-positive segment
  // width is rejected at elaboration, so the guard only avoids a divide by 0.
  function automatic int stage_count(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

  // Subtract forms feed the one's complement of b into the adder.
  function automatic logic inverts_b(input alu_op_e op);
    return (op == SUB) || (op == SBB);
  endfunction

  // Carry injected into the least significant segment.
  function automatic logic carry_in(input alu_op_e op, input logic cin);
    logic c;
    case (op)
      ADD:     c = 1'b0;
      ADC:     c = cin;
      SUB:     c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/add_seg_stage.sv
// One pipeline segment of the adder: a SEG-wide combinational add whose sum,
// carry-out and signed-overflow indication are captured when the pipe
// advances. The overflow bit only matters for the most significant segment.
module add_seg_stage #(
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           ovf
);

  logic [SEG:0] total;
  logic         c_msb;

  // Segment add; carry into the top bit is recovered from the sum bit.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    c_msb = a[SEG-1] ^ b[SEG-1] ^ total[SEG-1];
  end

  // Segment result registers, cleared by reset, loaded on pipeline advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG-1:0];
      cout <= total[SEG];
      ovf  <= c_msb ^ total[SEG];
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit built from SEG-wide registered segments.
// Stage k adds operand segment k with the carry registered by stage k-1;
// the still-unused upper operand bits and the finished lower result bits
// travel alongside so that every operation stays aligned down the pipe.
// A single global enable (adv) moves the whole pipe, bubbles included.
module pipe_adder
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = stage_count(WIDTH, SEG);

  if (SEG < 1) begin : g_bad_seg
    $error("pipe_adder: SEG must be at least 1");
  end else if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a multiple of SEG");
  end

  alu_op_e          op_dec;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             adv;
  logic [STAGES-1:0] vld_q;
  logic             seg_c   [STAGES];
  logic             seg_ovf [STAGES];

  // Opcode decode into the effective second operand and carry-in.
  always_comb begin
    op_dec = alu_op_e'(op);
    b_eff  = inverts_b(op_dec) ? ~b : b;
    c_eff  = carry_in(op_dec, cin);
  end

  // The pipe moves whenever the output slot is empty or being drained.
  assign adv       = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];

  // Valid bits shift with the data; an unaccepted cycle enters as a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_q[k] <= vld_q[k-1];
      end
      vld_q[0] <= in_valid;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    // Operand bits from segment k upward, as seen by this stage.
    logic [WIDTH-LO-1:0] a_src;
    logic [WIDTH-LO-1:0] b_src;
    logic                c_src;
    logic [SEG-1:0]      seg_sum;
    // Result bits finished once this stage has registered its segment.
    logic [HI-1:0]       done;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b_eff;
      assign c_src = c_eff;
      assign done  = seg_sum;
    end else begin : g_body
      logic [LO-1:0] res_lo_q;

      // Operand skew: carry the not-yet-added upper segments forward.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_src <= g_stage[k-1].a_src[WIDTH-LO+SEG-1:SEG];
          b_src <= g_stage[k-1].b_src[WIDTH-LO+SEG-1:SEG];
        end
      end

      // Result alignment: lower segments finished by earlier stages.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_lo_q <= '0;
        end else if (adv) begin
          res_lo_q <= g_stage[k-1].done;
        end
      end

      assign c_src = seg_c[k-1];
      assign done  = {seg_sum, res_lo_q};
    end

    add_seg_stage #(
      .SEG(SEG)
    ) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .a     (a_src[SEG-1:0]),
      .b     (b_src[SEG-1:0]),
      .cin   (c_src),
      .sum   (seg_sum),
      .cout  (seg_c[k]),
      .ovf   (seg_ovf[k])
    );
  end

  // Final stage outputs; zero is qualified by valid so it reads 0 in reset.
  assign sum  = g_stage[STAGES-1].done;
  assign cout = seg_c[STAGES-1];
  assign ovf  = seg_ovf[STAGES-1];
  assign zero = vld_q[STAGES-1] & ~(|sum);

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: a two-segment build and a single-stage build share
// the same stimulus; the selected one is checked against a reference model
// computed with wide integer arithmetic.
module tb_pipe_adder;
  import kgp_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cin;
  logic [1:0]  op;
  logic [31:0] a, b;

  logic        rdy2, vld2, c2, o2, z2;
  logic [31:0] s2;
  logic        rdy1, vld1, c1, o1, z1;
  logic [31:0] s1;

  bit          use1;
  logic        m_ready, m_valid, m_cout, m_ovf, m_zero;
  logic [31:0] m_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .SEG(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(vld2), .out_ready(out_ready),
    .sum(s2), .cout(c2), .ovf(o2), .zero(z2)
  );

  pipe_adder #(.WIDTH(32), .SEG(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(vld1), .out_ready(out_ready),
    .sum(s1), .cout(c1), .ovf(o1), .zero(z1)
  );

  always_comb begin
    if (use1) begin
      m_ready = rdy1; m_valid = vld1; m_sum = s1; m_cout = c1; m_ovf = o1; m_zero = z1;
    end else begin
      m_ready = rdy2; m_valid = vld2; m_sum = s2; m_cout = c2; m_ovf = o2; m_zero = z2;
    end
  end

  function automatic int lat();
    return use1 ? 1 : 2;
  endfunction

  // Reference: {sum, cout, ovf, zero} from exact unsigned and signed values.
  function automatic logic [34:0] model(input logic [1:0] fop, input logic [31:0] fa,
                                        input logic [31:0] fb, input logic fc);
    longint ua, ub, sa, sb, us, ss;
    logic   co, ov;
    logic [31:0] r;
    ua = longint'({32'b0, fa});
    ub = longint'({32'b0, fb});
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    case (fop)
      2'd0: begin us = ua + ub;      ss = sa + sb;      end
      2'd1: begin us = ua + ub + (fc ? 1 : 0); ss = sa + sb + (fc ? 1 : 0); end
      2'd2: begin us = ua - ub;      ss = sa - sb;      end
      default: begin us = ua - ub - (fc ? 0 : 1); ss = sa - sb - (fc ? 0 : 1); end
    endcase
    if (fop < 2'd2) co = (us >= 64'sd4294967296);
    else            co = (us >= 0);
    ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    r  = us[31:0];
    return {r, co, ov, (r == 32'd0)};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b want 0 (single=%0d)", m_valid, use1);
    end
    n_cmp++;
    if ({m_sum, m_cout, m_ovf, m_zero} !== 35'd0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0 (single=%0d)", {m_sum, m_cout, m_ovf, m_zero}, use1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (m_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", m_ready, m_valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [9] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2};
    logic [31:0] t_a   [9] = '{32'h0000FFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0,
                               32'd10, 32'h0000FFFF, 32'd1, 32'd7};
    logic [31:0] t_b   [9] = '{32'd1, 32'd1, 32'd1, 32'd5, 32'd1, 32'd3, 32'd0, 32'd1, 32'd2};
    logic        t_c   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [34:0] t_exp [9] = '{{32'h00010000, 3'b000}, {32'h80000000, 3'b010},
                               {32'h00000000, 3'b101}, {32'h00000000, 3'b101},
                               {32'hFFFFFFFF, 3'b000}, {32'h00000006, 3'b100},
                               {32'h00010000, 3'b000}, {32'h00000002, 3'b000},
                               {32'h00000005, 3'b100}};
    int cnt;
    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b1; in_valid = 1'b1;
      op = t_op[i]; a = t_a[i]; b = t_b[i]; cin = t_c[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 1;
      while (!m_valid && cnt < 8) begin @(posedge clk); #1; cnt++; end
      n_cmp++;
      if (cnt != lat()) begin
        n_err++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, cnt, lat());
      end
      n_cmp++;
      if ({m_sum, m_cout, m_ovf, m_zero} !== t_exp[i]) begin
        n_err++; $display("FAIL directed_result[%0d] got %h want %h", i, {m_sum, m_cout, m_ovf, m_zero}, t_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  bop [6];
    logic [31:0] ba [6], bb [6];
    logic        bc [6];
    logic [34:0] q[$];
    logic [34:0] got, held;
    bit held_valid = 0, after_stall = 0;
    int idx = 0, nout = 0, cyc = 0, stall_left = -1, last_pop = 0, post_pops = 0;
    for (int i = 0; i < 6; i++) begin
      bop[i] = 2'($urandom_range(0, 3)); ba[i] = rnd_word(); bb[i] = rnd_word(); bc[i] = 1'($urandom);
    end
    while (nout < 6 && cyc < 60) begin
      in_valid = (idx < 6);
      if (idx < 6) begin op = bop[idx]; a = ba[idx]; b = bb[idx]; cin = bc[idx]; end
      out_ready = !(stall_left > 0);
      #1;
      got = {m_sum, m_cout, m_ovf, m_zero};
      if (m_valid && !out_ready) begin
        n_cmp++;
        if (m_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b_stall_in_ready got %b want 0", m_ready);
        end
        if (held_valid) begin
          n_cmp++;
          if (got !== held) begin
            n_err++; $display("FAIL b2b_stall_hold got %h want %h", got, held);
          end
        end
        held = got; held_valid = 1;
      end else begin
        held_valid = 0;
      end
      if (m_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_result got %h want none", got);
        end else begin
          if (got !== q[0]) begin
            n_err++; $display("FAIL b2b_result[%0d] got %h want %h", nout, got, q[0]);
          end
          void'(q.pop_front());
        end
        if (after_stall) begin
          if (post_pops > 0) begin
            n_cmp++;
            if (cyc != last_pop + 1) begin
              n_err++; $display("FAIL b2b_throughput got cycle %0d want %0d", cyc, last_pop + 1);
            end
          end
          post_pops++;
        end
        last_pop = cyc;
        nout++;
        if (stall_left < 0) stall_left = 3;
      end
      if (in_valid && m_ready) begin
        q.push_back(model(op, a, b, cin));
        idx++;
      end
      if (!out_ready) begin
        stall_left--;
        if (stall_left == 0) after_stall = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (nout != 6 || q.size() != 0) begin
      n_err++; $display("FAIL b2b_count got %0d results want 6 (pending %0d)", nout, q.size());
    end
  endtask

  task automatic test_random(input int ncyc);
    logic [34:0] q[$];
    logic [34:0] got, held;
    bit held_valid = 0;
    int cyc = 0;
    while (cyc < ncyc || (q.size() > 0 && cyc < ncyc + 40)) begin
      if (cyc < ncyc) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 3) != 0);
        op = 2'($urandom_range(0, 3)); a = rnd_word(); b = rnd_word(); cin = 1'($urandom);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      got = {m_sum, m_cout, m_ovf, m_zero};
      if (m_valid && !out_ready) begin
        n_cmp++;
        if (m_ready !== 1'b0 || (held_valid && got !== held)) begin
          n_err++; $display("FAIL rand_stall got rdy=%b out=%h want rdy=0 out=%h", m_ready, got, held);
        end
        held = got; held_valid = 1;
      end else begin
        held_valid = 0;
      end
      if (m_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_result got %h want none", got);
        end else begin
          if (got !== q[0]) begin
            n_err++; $display("FAIL rand_result got %h want %h", got, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && m_ready) q.push_back(model(op, a, b, cin));
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL rand_lost got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    int cnt;
    out_ready = 1'b0; in_valid = 1'b1; op = ADD; cin = 1'b0;
    a = rnd_word(); b = rnd_word();
    @(posedge clk); #1;
    a = rnd_word(); b = rnd_word();
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_valid got %b want 0", m_valid);
    end
    n_cmp++;
    if ({m_sum, m_cout, m_ovf, m_zero} !== 35'd0) begin
      n_err++; $display("FAIL midreset_outputs got %h want 0", {m_sum, m_cout, m_ovf, m_zero});
    end
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL midreset_ghost got valid=1 want no result");
    end
    in_valid = 1'b1; op = ADD; a = 32'h12345678; b = 32'h0000FFFF; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!m_valid && cnt < 8) begin @(posedge clk); #1; cnt++; end
    n_cmp++;
    if (cnt != lat() || {m_sum, m_cout, m_ovf, m_zero} !== {32'h12355677, 3'b000}) begin
      n_err++; $display("FAIL midreset_after got lat=%0d out=%h want lat=%0d out=%h",
                        cnt, {m_sum, m_cout, m_ovf, m_zero}, lat(), {32'h12355677, 3'b000});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = ADD; a = '0; b = '0; cin = 1'b0; use1 = 0;
    for (int pass = 0; pass < 2; pass++) begin
      use1 = (pass == 1);
      test_reset();
      test_directed();
      test_back_to_back();
      idle(3);
      test_random(300);
      test_reset_midflight();
      idle(3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
